// File: rtl/tile_row_scroller.sv
// Piano-tile playfield generator: 7-row lane map, pixel offset, draw handshake.
// Build option: define TILE_NO_REPEAT_EN to avoid repeating the top row's lane.
module tile_row_scroller #(
    parameter int          TICK_DIV = 833333,
    parameter int          ROW_H    = 34,
    parameter int          STEP     = 1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       stop,
    input  logic       draw_done,
    output logic       draw_go,
    output logic [5:0] offset,
    output logic [2:0] line_0,
    output logic [2:0] line_1,
    output logic [2:0] line_2,
    output logic [2:0] line_3,
    output logic [2:0] line_4,
    output logic [2:0] line_5,
    output logic [2:0] line_6,
    output logic       row_exit,
    output logic [1:0] exit_lane
);
    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [6:0]    STEP7    = 7'(STEP);
    localparam logic [6:0]    ROW7     = 7'(ROW_H);
    localparam logic [2:0]    EMPTY    = 3'b100;

    typedef enum logic [1:0] {IDLE, DRAW, WAIT_TICK, ADVANCE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [6:0][2:0]  lines_q, lines_d;
    logic [5:0]       off_q, off_d;
    logic             go_q, go_d;
    logic             pend_q, pend_d;
    logic             exit_q, exit_d;
    logic [1:0]       elane_q, elane_d;
    logic [6:0]       sum;
    logic             wrap;
    logic             accept;
    logic [1:0]       lane;

    assign sum    = {1'b0, off_q} + STEP7;
    assign wrap   = (sum >= ROW7);
    assign accept = go_q & draw_done;

`ifdef TILE_NO_REPEAT_EN
    assign lane = (!lines_q[0][2] && (lfsr_q[1:0] == lines_q[0][1:0]))
                ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];
`else
    assign lane = lfsr_q[1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        lfsr_d  = lfsr_q;
        lines_d = lines_q;
        off_d   = off_q;
        pend_d  = pend_q;
        exit_d  = 1'b0;
        elane_d = elane_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAW;
                    lines_d = {7{EMPTY}};
                    off_d   = '0;
                end
            end
            DRAW: begin
                if (stop) pend_d = 1'b1;
                if (accept) state_d = (stop | pend_q) ? IDLE : WAIT_TICK;
            end
            WAIT_TICK: begin
                if (stop | pend_q) state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = ADVANCE;
                else cnt_d = cnt_q + 1'b1;
            end
            ADVANCE: begin
                state_d = DRAW;
                if (stop) pend_d = 1'b1;
                if (!wrap) begin
                    off_d = sum[5:0];
                end else begin
                    off_d   = 6'(sum - ROW7);
                    lines_d = {lines_q[5:0], {1'b0, lane}};
                    lfsr_d  = {1'b0, lfsr_q[15:1]}
                            ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
                    exit_d  = !lines_q[6][2];
                    if (!lines_q[6][2]) elane_d = lines_q[6][1:0];
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) pend_d = 1'b0;
        // First DRAW cycle after start keeps draw_go low for one cycle
        go_d = (state_d == DRAW) && (state_q != IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= SEED;
            lines_q <= {7{EMPTY}};
            off_q   <= '0;
            go_q    <= 1'b0;
            pend_q  <= 1'b0;
            exit_q  <= 1'b0;
            elane_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            lines_q <= lines_d;
            off_q   <= off_d;
            go_q    <= go_d;
            pend_q  <= pend_d;
            exit_q  <= exit_d;
            elane_q <= elane_d;
        end
    end

    assign draw_go   = go_q;
    assign offset    = off_q;
    assign line_0    = lines_q[0];
    assign line_1    = lines_q[1];
    assign line_2    = lines_q[2];
    assign line_3    = lines_q[3];
    assign line_4    = lines_q[4];
    assign line_5    = lines_q[5];
    assign line_6    = lines_q[6];
    assign row_exit  = exit_q;
    assign exit_lane = elane_q;
endmodule

// File: tb/tb_tile_row_scroller.sv
// Self-checking bench for tile_row_scroller with a queue-based playfield model.
// Small geometry (TICK_DIV=4, ROW_H=4, STEP=1) keeps frames short.
module tb_tile_row_scroller;
    localparam int          T    = 4;
    localparam int          RH   = 4;
    localparam int          ST   = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, stop, draw_done;
    logic       draw_go, row_exit;
    logic [5:0] offset;
    logic [1:0] exit_lane;
    logic [2:0] l0, l1, l2, l3, l4, l5, l6;
    logic [2:0] dl [7];

    int errors = 0;
    int checks = 0;

    int         m_off;
    logic [2:0] m_q [$];
    logic [15:0] m_lfsr;
    int         m_wraps;

    tile_row_scroller #(
        .TICK_DIV(T), .ROW_H(RH), .STEP(ST), .SEED(SEED)
    ) dut (
        .clock(clk), .resetn(rstn), .start(start), .stop(stop),
        .draw_done(draw_done), .draw_go(draw_go), .offset(offset),
        .line_0(l0), .line_1(l1), .line_2(l2), .line_3(l3),
        .line_4(l4), .line_5(l5), .line_6(l6),
        .row_exit(row_exit), .exit_lane(exit_lane)
    );

    always #5 clk = ~clk;

    always_comb begin
        dl[0] = l0; dl[1] = l1; dl[2] = l2; dl[3] = l3;
        dl[4] = l4; dl[5] = l5; dl[6] = l6;
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_start();
        m_q = {};
        repeat (7) m_q.push_back(3'd4);
        m_off   = 0;
        m_wraps = 0;
    endtask

    task automatic model_step(output bit ex, output logic [1:0] el);
        int s;
        s  = m_off + ST;
        ex = 1'b0;
        el = 2'd0;
        if (s < RH) begin
            m_off = s;
        end else begin
            logic [1:0] ln;
            ln = m_lfsr[1:0];
`ifdef TILE_NO_REPEAT_EN
            if (m_q[0] != 3'd4 && m_q[0][1:0] == ln) ln = ln + 2'd1;
`endif
            m_off = s - RH;
            ex = (m_q[6] != 3'd4);
            el = m_q[6][1:0];
            void'(m_q.pop_back());
            m_q.push_front({1'b0, ln});
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            m_wraps++;
        end
    endtask

    // One full frame: draw_go high on entry and again on return.
    task automatic run_frame(input int hold, input bit poke, output bit ex);
        logic [1:0] el;
        checks++;
        if (draw_go !== 1'b1) begin
            errors++;
            $display("FAIL frame_go: draw_go=%0b want 1", draw_go);
        end
        for (int h = 0; h < hold; h++) begin
            draw_done = 1'b0;
            cyc();
            checks++;
            if (draw_go !== 1'b1 || offset !== 6'(m_off) || row_exit !== 1'b0) begin
                errors++;
                $display("FAIL hold: go=%0b off=%0d exit=%0b want 1 %0d 0",
                         draw_go, offset, row_exit, m_off);
            end
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (dl[i] !== m_q[i]) begin
                    errors++;
                    $display("FAIL hold_line%0d: got %0d want %0d", i, dl[i], m_q[i]);
                end
            end
        end
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        checks++;
        if (draw_go !== 1'b0 || row_exit !== 1'b0) begin
            errors++;
            $display("FAIL accept: go=%0b exit=%0b want 0 0", draw_go, row_exit);
        end
        for (int k = 1; k <= T; k++) begin
            draw_done = 1'($urandom_range(0, 1));
            start = poke && (k == 1);
            cyc();
            start = 1'b0;
            checks++;
            if (draw_go !== 1'b0 || offset !== 6'(m_off)) begin
                errors++;
                $display("FAIL wait%0d: go=%0b off=%0d want 0 %0d",
                         k, draw_go, offset, m_off);
            end
        end
        draw_done = 1'b0;
        cyc();
        model_step(ex, el);
        checks++;
        if (draw_go !== 1'b1 || offset !== 6'(m_off)) begin
            errors++;
            $display("FAIL advance: go=%0b off=%0d want 1 %0d", draw_go, offset, m_off);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dl[i] !== m_q[i]) begin
                errors++;
                $display("FAIL line%0d: got %0d want %0d", i, dl[i], m_q[i]);
            end
        end
        checks++;
        if (row_exit !== ex || (ex && exit_lane !== el)) begin
            errors++;
            $display("FAIL exit: got %0b/%0d want %0b/%0d", row_exit, exit_lane, ex, el);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; stop = 1'b0; draw_done = 1'b0;
        repeat (3) cyc();
        checks++;
        if (draw_go !== 1'b0 || offset !== 6'd0 || row_exit !== 1'b0 || exit_lane !== 2'd0) begin
            errors++;
            $display("FAIL reset_out: go=%0b off=%0d exit=%0b lane=%0d want 0",
                     draw_go, offset, row_exit, exit_lane);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dl[i] !== 3'd4) begin
                errors++;
                $display("FAIL reset_line%0d: got %0d want 4", i, dl[i]);
            end
        end
        rstn = 1'b1;
        m_lfsr = SEED;
        model_start();
        cyc();
    endtask

    task automatic test_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (draw_go !== 1'b0) begin
            errors++;
            $display("FAIL start_n: draw_go=%0b want 0", draw_go);
        end
        cyc();
        checks++;
        if (draw_go !== 1'b1) begin
            errors++;
            $display("FAIL start_n1: draw_go=%0b want 1", draw_go);
        end
        model_start();
    endtask

    task automatic test_step_wrap();
        int exp_off [4] = '{1, 2, 3, 0};
        bit ex;
        for (int i = 0; i < 4; i++) begin
            run_frame(0, 0, ex);
            checks++;
            if (offset !== 6'(exp_off[i])) begin
                errors++;
                $display("FAIL step%0d: off=%0d want %0d", i, offset, exp_off[i]);
            end
        end
        checks++;
        if (l0 !== 3'd1 || l1 !== 3'd4) begin
            errors++;
            $display("FAIL first_wrap: l0=%0d l1=%0d want 1 4", l0, l1);
        end
    endtask

    task automatic test_exit();
        bit ex;
        int guard = 0;
        while (m_wraps < 8 && guard < 100) begin
            run_frame(0, 0, ex);
            guard++;
        end
        checks++;
        if (row_exit !== 1'b1 || exit_lane !== 2'd1) begin
            errors++;
            $display("FAIL exit8: exit=%0b lane=%0d want 1 1", row_exit, exit_lane);
        end
    endtask

    task automatic test_hold();
        bit ex;
        run_frame(100, 0, ex);
    endtask

    task automatic test_random();
        bit ex;
        for (int f = 0; f < 60; f++)
            run_frame($urandom_range(0, 5), 1'($urandom_range(0, 1)), ex);
    endtask

    task automatic test_stop_draw();
        bit ex;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (5) begin
            cyc();
            checks++;
            if (draw_go !== 1'b1) begin
                errors++;
                $display("FAIL stop_hold: draw_go=%0b want 1", draw_go);
            end
        end
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        repeat (T + 5) begin
            cyc();
            checks++;
            if (draw_go !== 1'b0 || offset !== 6'(m_off)) begin
                errors++;
                $display("FAIL stop_idle: go=%0b off=%0d want 0 %0d", draw_go, offset, m_off);
            end
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dl[i] !== m_q[i]) begin
                errors++;
                $display("FAIL stop_line%0d: got %0d want %0d", i, dl[i], m_q[i]);
            end
        end
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        model_start();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dl[i] !== 3'd4) begin
                errors++;
                $display("FAIL restart_line%0d: got %0d want 4", i, dl[i]);
            end
        end
        cyc();
        run_frame(0, 0, ex);
        run_frame(1, 0, ex);
    endtask

    task automatic test_stop_wait();
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (T + 4) begin
            cyc();
            checks++;
            if (draw_go !== 1'b0 || offset !== 6'(m_off)) begin
                errors++;
                $display("FAIL stopw_idle: go=%0b off=%0d want 0 %0d", draw_go, offset, m_off);
            end
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        model_start();
        checks++;
        if (draw_go !== 1'b1 || offset !== 6'd0) begin
            errors++;
            $display("FAIL stopw_restart: go=%0b off=%0d want 1 0", draw_go, offset);
        end
    endtask

    task automatic test_reset_mid();
        bit ex;
        for (int f = 0; f < 5; f++) run_frame(0, 0, ex);
        rstn = 1'b0;
        #1;
        checks++;
        if (draw_go !== 1'b0 || offset !== 6'd0 || row_exit !== 1'b0 || l0 !== 3'd4) begin
            errors++;
            $display("FAIL reset_mid: go=%0b off=%0d exit=%0b l0=%0d want 0 0 0 4",
                     draw_go, offset, row_exit, l0);
        end
        cyc();
        rstn = 1'b1;
        m_lfsr = SEED;
        cyc();
        test_start();
        for (int f = 0; f < 4; f++) run_frame(0, 0, ex);
        checks++;
        if (l0 !== 3'd1) begin
            errors++;
            $display("FAIL reseed: l0=%0d want 1", l0);
        end
    endtask

`ifdef TILE_NO_REPEAT_EN
    task automatic test_no_repeat();
        bit ex;
        int target;
        target = m_wraps + 1000;
        while (m_wraps < target) begin
            run_frame(0, 0, ex);
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (dl[i] != 3'd4 && dl[i + 1] != 3'd4 && dl[i] == dl[i + 1]) begin
                    errors++;
                    $display("FAIL no_repeat%0d: lane %0d repeated", i, dl[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_start();
        test_step_wrap();
        test_exit();
        test_hold();
        test_random();
        test_stop_draw();
        test_stop_wait();
        test_reset_mid();
`ifdef TILE_NO_REPEAT_EN
        test_no_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
